// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared types, constants and helpers for the serial BCD adder.
//            state_t    - control FSM states
//            DIGIT_W    - bits per BCD digit
//            BCD_MAX    - largest legal BCD digit value
//            BCD_CORR   - decimal correction added when a digit sum exceeds 9
//            nines_comp - nine's complement of one digit (4-bit wrap)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int                 DIGIT_W  = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

  // Digits above 9 wrap modulo 16 rather than saturating, so an invalid
  // operand still yields a deterministic result.
  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
    return BCD_MAX - d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_adder_if
// Purpose  : Request/result bundle of the serial BCD adder.
//            start, subtract, addend, augend, carry_in : requester -> adder
//            busy, done, sum, carry_out, invalid       : adder -> requester
//            Modport master = requester side, slave = adder side.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  localparam int W = bcd_pkg::DIGIT_W * DIGITS;

  logic         start;
  logic         subtract;
  logic [W-1:0] addend;
  logic [W-1:0] augend;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         invalid;

  modport master (
    output start, subtract, addend, augend, carry_in,
    input  busy, done, sum, carry_out, invalid
  );

  modport slave (
    input  start, subtract, addend, augend, carry_in,
    output busy, done, sum, carry_out, invalid
  );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adder
// Purpose  : Combinational single-digit BCD adder.
//            a, b  : input digits (values above 9 tolerated)
//            cin   : carry in
//            digit : corrected result digit
//            cout  : decimal carry out
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] digit,
  output logic               cout
);

  logic [DIGIT_W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    if (raw > {1'b0, BCD_MAX}) begin
      // Adding 6 in 4-bit arithmetic equals (raw + 6) mod 16.
      digit = raw[DIGIT_W-1:0] + BCD_CORR;
      cout  = 1'b1;
    end else begin
      digit = raw[DIGIT_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_adder
// Purpose  : Multi-digit BCD add/subtract, one digit per clock, LSD first.
//            clk   : rising-edge clock
//            rst_n : asynchronous active-low reset
//            bus   : slave side of bcd_serial_adder_if (start/subtract/
//                    operands/carry_in in; busy/done/sum/carry_out/invalid out)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_serial_adder_if.slave        bus
);

  localparam int               W     = DIGIT_W * DIGITS;
  localparam int               CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGITS - 1);

  state_t             state, state_nx;
  logic [W-1:0]       a_sr, b_sr, sum_r, sum_shift;
  logic [CNT_W-1:0]   idx;
  logic               sub_r, carry_r, carry_out_r, invalid_r;
  logic               accept, last_digit, raw_invalid;
  logic [DIGIT_W-1:0] b_digit, digit;
  logic               cout;

  assign accept     = bus.start && ((state == IDLE) || (state == DONE));
  assign last_digit = (idx == LAST);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last_digit) state_nx = DONE;
      DONE:    state_nx = bus.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Flag is taken from the raw operands at the accepting edge.
  always_comb begin
    raw_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((bus.addend[i*DIGIT_W +: DIGIT_W] > BCD_MAX) ||
          (bus.augend[i*DIGIT_W +: DIGIT_W] > BCD_MAX))
        raw_invalid = 1'b1;
    end
  end

  // ---------------- digit datapath ----------------
  assign b_digit = sub_r ? nines_comp(b_sr[DIGIT_W-1:0]) : b_sr[DIGIT_W-1:0];

  bcd_digit_adder u_digit (
    .a     (a_sr[DIGIT_W-1:0]),
    .b     (b_digit),
    .cin   (carry_r),
    .digit (digit),
    .cout  (cout)
  );

  // New digit enters at the MSB end so that after DIGITS shifts digit 0
  // sits in bits [3:0].
  generate
    if (DIGITS == 1) begin : g_single
      assign sum_shift = digit;
    end else begin : g_multi
      assign sum_shift = {digit, sum_r[W-1:DIGIT_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr        <= '0;
      b_sr        <= '0;
      sum_r       <= '0;
      idx         <= '0;
      sub_r       <= 1'b0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      invalid_r   <= 1'b0;
    end else if (accept) begin
      a_sr      <= bus.addend;
      b_sr      <= bus.augend;
      sub_r     <= bus.subtract;
      // Subtract is A + 9's(B) + 1; a borrow-in removes the +1.
      carry_r   <= bus.carry_in ^ bus.subtract;
      idx       <= '0;
      invalid_r <= raw_invalid;
    end else if (state == RUN) begin
      a_sr    <= a_sr >> DIGIT_W;
      b_sr    <= b_sr >> DIGIT_W;
      sum_r   <= sum_shift;
      carry_r <= cout;
      idx     <= idx + 1'b1;
      if (last_digit) carry_out_r <= cout;
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
  assign bus.invalid   = invalid_r;

endmodule
`default_nettype wire

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised multi-digit BCD add/subtract unit that processes one decimal digit per clock, least-significant digit first. It extends our single-stage 4-bit BCD adder to DIGITS digits, adds a nine's-complement subtract mode, invalid-digit detection and a Start/Busy/Done handshake. It sits between operand registers and the display/accumulator path and trades latency for a single digit-adder datapath.

## Interface
- DIGITS, default 4, number of BCD digits per operand (≥1)
- Clock  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  request; sampled only in IDLE or DONE
- Subtract  input  1  0 = Addend+Augend, 1 = Addend−Augend; latched with Start
- Addend  input  4*DIGITS  BCD operand A, digit 0 in bits [3:0]; latched with Start
- Augend  input  4*DIGITS  BCD operand B; latched with Start
- Carry_in  input  1  add: carry into digit 0; subtract: borrow-in (active high); latched with Start
- Busy  output  1  high while digits are being processed
- Done  output  1  one-cycle pulse, result valid
- Sum  output  4*DIGITS  BCD result, held from Done until next accepted Start
- Carry_out  output  1  final decimal carry; in subtract, 1 = no borrow (A−B−Carry_in ≥ 0)
- Invalid  output  1  any latched operand digit > 9

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; Busy, Done, Sum, Carry_out and Invalid all 0.
- IDLE/DONE + Start=1: latch operands, Subtract, Carry_in; digit index ← 0; carry ← Carry_in (add) or ~Carry_in (subtract); Invalid ← OR of per-digit (>9) over both raw operands; → RUN.
- DONE + Start=0 → IDLE; Sum, Carry_out and Invalid hold.
- RUN, each cycle at digit index i: a = A digit i; b = B digit i, or 9−b in subtract mode (4-bit wrap for b > 9); s = a+b+carry (5 bits); if s > 9: digit = (s+6) mod 16, carry = 1; else digit = s, carry = 0. The digit is shifted into the Sum register from the MSB end. After i = DIGITS−1 → DONE, Carry_out ← carry.
- Invalid operands still produce a result using the same rule; only the Invalid flag is raised.
- Start during RUN is ignored; operands and mode do not change mid-operation.
- Sum is not cleared at Start; its contents are undefined from the accepting edge until Done.

## Timing
- Start accepted at edge k → Busy high for cycles k+1 … k+DIGITS → Done high for exactly cycle k+DIGITS+1.
- Total latency is DIGITS+1 edges. Throughput is one operation per DIGITS+1 cycles, with back-to-back Start accepted in the DONE cycle.
- Invalid is updated at the accepting edge and holds until the next accepted Start.
- Reset_n low at any time, including mid-RUN, forces IDLE and clears all outputs asynchronously. The first Start is sampled at the first rising edge after deassertion.

## Structure
- Shared package bcd_pkg:
  - state enum {IDLE, RUN, DONE}
  - DIGIT_W = 4, BCD_MAX = 9, BCD_CORR = 6
  - nine's-complement helper function
- Sub-module bcd_digit_adder: combinational single-digit add, (a, b, cin) → (digit, cout), implementing the >9/+6 rule. It is instantiated once.
- Top-level logic: FSM, digit counter of width $clog2(DIGITS+1), operand shift registers, carry flop, Sum shift register.

## Test plan
- DIGITS=4, add 1234+5678, Carry_in=0 → Busy for 4 cycles, Done at k+5, Sum=6912, Carry_out=0, Invalid=0.
- Add 9999+0001, Carry_in=0 → Sum=0000, Carry_out=1; repeat with 9999+0000, Carry_in=1 → same result.
- Subtract 5000−1234 → Sum=3766, Carry_out=1; subtract 1234−5000 → Sum=6234 (ten's complement), Carry_out=0.
- Add 00A0+0001 → Invalid=1, Sum=0101, Carry_out=0. A following valid Start (0001+0001) → Invalid=0, Sum=0002.
- Start pulses during RUN → ignored, result unchanged. Start asserted in the DONE cycle → new operation accepted, Busy at the next cycle.
- Reset_n pulsed low at RUN digit 2 → all outputs 0 immediately, state IDLE. After release, a fresh 0005+0005 → Sum=0010. Also run DIGITS=1 with 7+8 → Sum=5, Carry_out=1, Done at k+2.
